// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : CPU_def (package)
//  Description : Shared definitions for the MIPS core front end: PC width,
//                reset fetch address and the fetch-stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package CPU_def;

    localparam int unsigned PC_BITS  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // only reachable from reset
        REQ  = 2'd1,   // request presented, waiting for acceptance
        WAIT = 2'd2,   // one request outstanding, waiting for response
        HOLD = 2'd3    // fetched word held while decode is stalled
    } fetch_state_t;

endpackage : CPU_def
`default_nettype wire

// File: rtl/fetch_unit_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_cnt
//  Description : Two saturating event counters for the fetch stage
//                (captured responses and discarded wrong-path responses).
//  Ports       : clk        - clock, rising edge
//                clr_n      - asynchronous active-low reset
//                fetch_inc  - one captured response this cycle
//                kill_inc   - one discarded response this cycle
//                fetch_cnt  - captured response count (saturating)
//                kill_cnt   - discarded response count (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             fetch_inc,
    input  logic             kill_inc,
    output logic [WIDTH-1:0] fetch_cnt,
    output logic [WIDTH-1:0] kill_cnt
);

    logic [WIDTH-1:0] r_fetch_cnt;
    logic [WIDTH-1:0] r_kill_cnt;

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_fetch_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (fetch_inc && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + WIDTH'(1);
            end
            if (kill_inc && (r_kill_cnt != '1)) begin
                r_kill_cnt <= r_kill_cnt + WIDTH'(1);
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign kill_cnt  = r_kill_cnt;

endmodule : fetch_perf_cnt
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues one
//                instruction-memory request at a time, presents the fetched
//                word to the fetch/decode register, honours stall_f and
//                discards responses made stale by a decode redirect.
//  Options     : FETCH_PERF_EN - adds fetch_cnt / kill_cnt counter outputs.
//  Ports       : clk, clr_n (async active-low reset)
//                stall_f            - hold fetch outputs
//                pc_src_d           - redirect pulse, target pc_branch_d
//                imem_req/imem_addr - request, stable until imem_ready
//                imem_ready         - request accepted this cycle
//                imem_rvalid/rdata  - instruction response
//                instr_f/pc_plus_4f/valid_f - to fetch/decode register
//                fetch_cnt/kill_cnt - perf counters (FETCH_PERF_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import CPU_def::*;
#(
    parameter int unsigned        PC_BITS  = CPU_def::PC_BITS,
    parameter logic [PC_BITS-1:0] RESET_PC = PC_BITS'(CPU_def::RESET_PC)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               stall_f,
    input  logic               pc_src_d,
    input  logic [PC_BITS-1:0] pc_branch_d,
    output logic               imem_req,
    output logic [PC_BITS-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [PC_BITS-1:0] imem_rdata,
    output logic [PC_BITS-1:0] instr_f,
    output logic [PC_BITS-1:0] pc_plus_4f,
    output logic               valid_f
`ifdef FETCH_PERF_EN
   ,output logic [31:0]        fetch_cnt,
    output logic [31:0]        kill_cnt
`endif
);

    localparam logic [PC_BITS-1:0] c_pc_step = PC_BITS'(4);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               r_kill;
    logic               w_kill_nxt;
    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] w_pc_nxt;
    logic [PC_BITS-1:0] r_addr;
    logic [PC_BITS-1:0] r_instr;
    logic [PC_BITS-1:0] r_pc_plus_4;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               w_capture;
    logic [PC_BITS-1:0] w_pc_inc;
    logic [PC_BITS-1:0] w_target;
    logic               w_unused_bits;

    assign w_pc_inc      = r_pc + c_pc_step;
    assign w_target      = {pc_branch_d[PC_BITS-1:2], 2'b00};
    assign w_unused_bits = &{1'b0, pc_branch_d[1:0]};

    // ------------------------------------------------------------------
    // Next-state logic. A redirect outranks both stall_f and rvalid.
    // r_kill marks the single outstanding response as wrong-path; it is
    // only set when a request is (or will be) in flight, so it can never
    // cover more than one response.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    w_state_nxt = WAIT;
                end
                if (pc_src_d) begin
                    w_kill_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (pc_src_d || r_kill) begin
                        // Wrong-path response: drop it, PC already holds
                        // (or is now loaded with) the target.
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = stall_f ? HOLD : REQ;
                    end
                end else if (pc_src_d) begin
                    w_kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (pc_src_d || !stall_f) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (pc_src_d) begin
            w_pc_nxt = w_target;
        end else if (w_capture) begin
            w_pc_nxt = w_pc_inc;
        end
    end

    // valid_f drops once decode consumes it (valid and not stalled),
    // unless a fresh word lands in the same cycle.
    always_comb begin
        w_valid_nxt = r_valid;
        if (pc_src_d) begin
            w_valid_nxt = 1'b0;
        end else if (w_capture) begin
            w_valid_nxt = 1'b1;
        end else if (r_valid && !stall_f) begin
            w_valid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, PC and output registers. r_addr tracks the PC while no
    // request is being presented and freezes in REQ, so a redirect during
    // an unaccepted request does not disturb the address on the bus.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_instr     <= '0;
            r_pc_plus_4 <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state != REQ) begin
                r_addr <= w_pc_nxt;
            end
            if (w_capture) begin
                r_instr     <= imem_rdata;
                r_pc_plus_4 <= w_pc_inc;
            end
            r_valid <= w_valid_nxt;
        end
    end

    assign imem_req   = (r_state == REQ);
    assign imem_addr  = r_addr;
    assign instr_f    = r_instr;
    assign pc_plus_4f = r_pc_plus_4;
    assign valid_f    = r_valid;

`ifdef FETCH_PERF_EN
    logic w_discard;
    assign w_discard = (r_state == WAIT) && imem_rvalid && (pc_src_d || r_kill);

    fetch_perf_cnt #(
        .WIDTH     (32)
    ) u_perf_cnt (
        .clk       (clk),
        .clr_n     (clr_n),
        .fetch_inc (w_capture),
        .kill_inc  (w_discard),
        .fetch_cnt (fetch_cnt),
        .kill_cnt  (kill_cnt)
    );
`else
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A second
//                instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap.
//                Memory responds with rdata = addr ^ 32'hA5A5_A5A5 after a
//                programmable number of extra cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_key = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        stall_f;
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_f;
    logic [31:0] pc_plus_4f;
    logic        valid_f;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] kill_cnt;
    logic [31:0] fetch_cnt2;
    logic [31:0] kill_cnt2;
`endif

    int          n_cmp = 0;
    int          n_err = 0;

    // memory model state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          lat = 0;
    logic        pend2 = 1'b0;
    logic [31:0] pend2_addr = '0;
    int          n_resp2 = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .stall_f     (stall_f),
        .pc_src_d    (pc_src_d),
        .pc_branch_d (pc_branch_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_f     (instr_f),
        .pc_plus_4f  (pc_plus_4f),
        .valid_f     (valid_f)
`ifdef FETCH_PERF_EN
       ,.fetch_cnt   (fetch_cnt),
        .kill_cnt    (kill_cnt)
`endif
    );

    fetch_unit #(
        .PC_BITS     (32),
        .RESET_PC    (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk         (clk),
        .clr_n       (clr_n),
        .stall_f     (1'b0),
        .pc_src_d    (1'b0),
        .pc_branch_d (32'h0),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ready  (1'b1),
        .imem_rvalid (rvalid2),
        .imem_rdata  (rdata2),
        .instr_f     (instr2),
        .pc_plus_4f  (pc4_2),
        .valid_f     (valid2)
`ifdef FETCH_PERF_EN
       ,.fetch_cnt   (fetch_cnt2),
        .kill_cnt    (kill_cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: note any acceptance, advance, then drive the response
    // for the new cycle. Returns #1 after the rising edge.
    task automatic cyc();
        if (imem_req && imem_ready) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = lat;
        end
        if (req2) begin
            pend2      = 1'b1;
            pend2_addr = addr2;
        end
        @(posedge clk);
        #1;
        if (pend && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr ^ c_key;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pend) pend_cnt--;
        end
        if (pend2) begin
            rvalid2 = 1'b1;
            rdata2  = pend2_addr ^ c_key;
            pend2   = 1'b0;
            n_resp2++;
        end else begin
            rvalid2 = 1'b0;
            rdata2  = '0;
        end
    endtask

    initial begin
        clr_n       = 1'b0;
        stall_f     = 1'b0;
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        rvalid2     = 1'b0;
        rdata2      = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_f),  32'd0);
        check("rst_instr", instr_f,       32'd0);
        check("rst_pc4",   pc_plus_4f,    32'd0);
        check("rst_req2",  32'(req2),     32'd0);
`ifdef FETCH_PERF_EN
        check("rst_fcnt",  fetch_cnt,     32'd0);
        check("rst_kcnt",  kill_cnt,      32'd0);
`endif

        // ---- straight-line fetch, ready=1, zero latency ----
        clr_n = 1'b1;
        cyc();
        check("first_req",   32'(imem_req), 32'd1);
        check("first_addr",  imem_addr,     32'h0);
        check("wrap_addr0",  addr2,         32'hFFFF_FFFC);
        cyc();
        check("wait_req",    32'(imem_req), 32'd0);
        cyc();
        check("cap0_instr",  instr_f,       32'h0 ^ c_key);
        check("cap0_pc4",    pc_plus_4f,    32'd4);
        check("cap0_valid",  32'(valid_f),  32'd1);
        check("req4_addr",   imem_addr,     32'd4);
        check("req4_req",    32'(imem_req), 32'd1);
        check("wrap_instr",  instr2,        32'hFFFF_FFFC ^ c_key);
        check("wrap_pc4",    pc4_2,         32'h0);
        check("wrap_valid",  32'(valid2),   32'd1);
        check("wrap_addr1",  addr2,         32'h0);

        // ---- stall for 5 cycles after capturing addr 4 ----
        cyc();
        check("consume_clr", 32'(valid_f),  32'd0);
        stall_f = 1'b1;
        cyc();
        check("cap4_instr",  instr_f,       32'd4 ^ c_key);
        check("cap4_pc4",    pc_plus_4f,    32'd8);
        check("cap4_valid",  32'(valid_f),  32'd1);
        check("hold_req",    32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("hold_instr", instr_f,       32'd4 ^ c_key);
            check("hold_valid", 32'(valid_f),  32'd1);
            check("hold_noreq", 32'(imem_req), 32'd0);
        end
        stall_f = 1'b0;
        cyc();
        check("unstall_req",  32'(imem_req), 32'd1);
        check("unstall_addr", imem_addr,     32'd8);
        check("unstall_vld",  32'(valid_f),  32'd0);

        // ---- redirect while waiting on addr 8 (response later) ----
        lat = 1;
        cyc();
        check("w8_req", 32'(imem_req), 32'd0);
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0100;
        cyc();
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        check("kill_valid", 32'(valid_f),  32'd0);
        check("kill_noreq", 32'(imem_req), 32'd0);
        cyc();
        check("drop8_valid", 32'(valid_f),  32'd0);
        check("tgt100_req",  32'(imem_req), 32'd1);
        check("tgt100_addr", imem_addr,     32'h100);
        lat = 0;
        cyc();
        cyc();
        check("cap100_instr", instr_f,      32'h100 ^ c_key);
        check("cap100_pc4",   pc_plus_4f,   32'h104);
        check("cap100_valid", 32'(valid_f), 32'd1);
        check("req104_addr",  imem_addr,    32'h104);

        // ---- redirect coincident with rvalid ----
        cyc();
        check("rv104_pending", 32'(imem_rvalid), 32'd1);
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0200;
        cyc();
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        check("coinc_req",   32'(imem_req), 32'd1);
        check("coinc_addr",  imem_addr,     32'h200);
        check("coinc_valid", 32'(valid_f),  32'd0);
        check("coinc_instr", instr_f,       32'h100 ^ c_key);
        cyc();
        stall_f = 1'b1;
        cyc();
        check("cap200_instr", instr_f,      32'h200 ^ c_key);
        check("cap200_pc4",   pc_plus_4f,   32'h204);
        check("cap200_valid", 32'(valid_f), 32'd1);
        cyc();
        check("hold200_valid", 32'(valid_f), 32'd1);

        // ---- redirect in HOLD with stall_f still high, low bits forced 0 ----
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0303;
        cyc();
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        check("holdredir_valid", 32'(valid_f),  32'd0);
        check("holdredir_req",   32'(imem_req), 32'd1);
        check("holdredir_addr",  imem_addr,     32'h300);
        stall_f = 1'b0;

        // ---- ready low 3 cycles, redirect in the middle ----
        imem_ready = 1'b0;
        cyc();
        check("rdylo1_addr", imem_addr, 32'h300);
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0400;
        cyc();
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        check("rdylo2_addr", imem_addr,     32'h300);
        check("rdylo2_req",  32'(imem_req), 32'd1);
        cyc();
        check("rdylo3_addr", imem_addr,     32'h300);
        imem_ready = 1'b1;
        cyc();
        check("acc300_req",  32'(imem_req), 32'd0);
        cyc();
        check("drop300_valid", 32'(valid_f),  32'd0);
        check("tgt400_addr",   imem_addr,     32'h400);
        check("tgt400_req",    32'(imem_req), 32'd1);
        cyc();
        cyc();
        check("cap400_instr", instr_f,      32'h400 ^ c_key);
        check("cap400_pc4",   pc_plus_4f,   32'h404);
        check("cap400_valid", 32'(valid_f), 32'd1);

`ifdef FETCH_PERF_EN
        // captures: 0, 4, 0x100, 0x200, 0x400; discards: 8, 0x104, 0x300
        check("perf_fetch",  fetch_cnt,  32'd5);
        check("perf_kill",   kill_cnt,   32'd3);
        check("perf_fetch2", fetch_cnt2, 32'(n_resp2) - 32'(rvalid2));
        check("perf_kill2",  kill_cnt2,  32'd0);
`endif

        // ---- async reset mid-transaction, late rvalid while in IDLE ----
        cyc();
        check("mid_wait_req", 32'(imem_req), 32'd0);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_req",   32'(imem_req), 32'd0);
        check("async_valid", 32'(valid_f),  32'd0);
        check("async_instr", instr_f,       32'd0);
        check("async_pc4",   pc_plus_4f,    32'd0);
`ifdef FETCH_PERF_EN
        check("async_fcnt",  fetch_cnt,     32'd0);
`endif
        pend        = 1'b0;
        pend2       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        cyc();
        check("rel_valid", 32'(valid_f),  32'd0);
        check("rel_instr", instr_f,       32'd0);
        check("rel_req",   32'(imem_req), 32'd1);
        check("rel_addr",  imem_addr,     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
